// File: rtl/updown_counter.sv
// Up/down counter with programmable step and run-time modulo limit, wrapping or saturating; one-cycle latency, no backpressure.
// Saturation is compiled in only when UPDOWN_COUNTER_SAT_EN is defined; otherwise sat_mode is ignored and the counter always wraps.
module updown_counter #(
  parameter int WIDTH  = 12,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load_sig,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              inc_sig,
  input  logic              dec_sig,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic              sat_mode,
  output logic [WIDTH-1:0]  ctr,
  output logic              ovf,
  output logic              at_zero,
  output logic              at_limit
);

  logic             sat;
  logic [WIDTH:0]   ctr_x, lim_x, step_x, lim_p1;
  logic [WIDTH:0]   sum, diff, wrap_up, wrap_dn;
  logic [WIDTH-1:0] nxt_ctr;
  logic             nxt_ovf;

`ifdef UPDOWN_COUNTER_SAT_EN
  assign sat = sat_mode;
`else
  logic unused_sat_mode;
  assign unused_sat_mode = sat_mode;
  assign sat = 1'b0;
`endif

  // All arithmetic is one bit wider than the count so nothing is lost before comparison.
  assign ctr_x   = {1'b0, ctr};
  assign lim_x   = {1'b0, limit};
  assign step_x  = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
  assign lim_p1  = lim_x + 1'b1;
  assign sum     = ctr_x + step_x;
  assign diff    = ctr_x - step_x;
  assign wrap_up = sum - lim_p1;
  assign wrap_dn = ctr_x + lim_p1 - step_x;

  always_comb begin
    nxt_ctr = ctr;
    nxt_ovf = 1'b0;
    if (clr) begin
      nxt_ctr = '0;
    end else if (load_sig) begin
      nxt_ctr = (load_val > limit) ? limit : load_val;
    end else if ((inc_sig ^ dec_sig) && (step != '0)) begin
      if (ctr > limit) begin
        // Limit was lowered beneath the current count: snap back into range.
        nxt_ctr = sat ? limit : '0;
        nxt_ovf = 1'b1;
      end else if (inc_sig) begin
        if (sum <= lim_x) begin
          nxt_ctr = WIDTH'(sum);
        end else begin
          nxt_ctr = sat ? limit : WIDTH'(wrap_up);
          nxt_ovf = 1'b1;
        end
      end else begin
        if (step_x <= ctr_x) begin
          nxt_ctr = WIDTH'(diff);
        end else begin
          nxt_ctr = sat ? '0 : WIDTH'(wrap_dn);
          nxt_ovf = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr <= '0;
      ovf <= 1'b0;
    end else begin
      ctr <= nxt_ctr;
      ovf <= nxt_ovf;
    end
  end

  assign at_zero  = (ctr == '0);
  assign at_limit = (ctr == limit);

endmodule
